// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer: REQ/ISSUE handshake with imem, branch select,
// misaligned-target and imem-timeout traps. Optional retire counter via `PC_RETIRE_COUNT_EN.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned TCNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCPlus4,
    input  logic [31:0] PCTarget,
    input  logic        PCSrc,
    input  logic        Stall,
    input  logic        ImemAck,
    output logic [31:0] PC,
    output logic        ImemReq,
    output logic        InstrValid,
    output logic        Trap,
    output logic [1:0]  TrapCause,
    output logic [31:0] RetireCount
);

    localparam int unsigned XLEN = 32;
    localparam bit TO_EN = (TIMEOUT != 0);
    // Last counter value before expiry; only meaningful when TO_EN.
    localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TIMEOUT - 1);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TOUT  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ISSUE = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [TCNT_W-1:0] tcnt;
    logic [TCNT_W-1:0] tcnt_d;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   pc_next;
    logic [1:0]        cause_d;
    logic              advance;
    logic              imemreq_d;
    logic              instrvalid_d;
    logic              trap_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, next PC, timeout counter and next output values
    always_comb begin
        state_d      = state;
        tcnt_d       = tcnt;
        pc_d         = PC;
        cause_d      = TrapCause;
        advance      = 1'b0;
        pc_next      = PCSrc ? PCTarget : PCPlus4;

        case (state)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // An ack in the expiry cycle takes priority over the timeout.
                if (ImemAck) begin
                    state_d = S_ISSUE;
                    tcnt_d  = '0;
                end else if (TO_EN && (tcnt == TLAST)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TOUT;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt + TCNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (!Stall) begin
                    if (pc_next[1:0] != 2'b00) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ALIGN;
                    end else begin
                        pc_d    = pc_next;
                        state_d = S_REQ;
                        advance = 1'b1;
                    end
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        imemreq_d    = (state_d == S_REQ);
        instrvalid_d = (state_d == S_ISSUE);
        trap_d       = (state_d == S_TRAP);
    end

    // Registered datapath and outputs, all reflecting the state just entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC         <= RESET_VECTOR;
            tcnt       <= '0;
            ImemReq    <= 1'b0;
            InstrValid <= 1'b0;
            Trap       <= 1'b0;
            TrapCause  <= CAUSE_NONE;
        end else begin
            PC         <= pc_d;
            tcnt       <= tcnt_d;
            ImemReq    <= imemreq_d;
            InstrValid <= instrvalid_d;
            Trap       <= trap_d;
            TrapCause  <= cause_d;
        end
    end

`ifdef PC_RETIRE_COUNT_EN
    logic [XLEN-1:0] retire_q;

    // Counts ISSUE->REQ advances; wraps naturally and cannot move once trapped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_q <= '0;
        end else if (advance) begin
            retire_q <= retire_q + XLEN'(1);
        end
    end

    assign RetireCount = retire_q;
`else
    logic unused_advance;

    assign unused_advance = advance;
    assign RetireCount    = '0;
`endif

endmodule
